// File: rtl/icache_refill_pkg.sv
// Shared constants and state encoding for the I-cache refill engine.
// Geometry: 64 sets of 64-byte lines, filled by 32-bit memory beats.
package icache_refill_pkg;

  localparam int icache_pc_size   = 32;
  localparam int icache_memw      = 32;
  localparam int icache_blocksize = 512;
  localparam int icache_noofsets  = 64;

  localparam int icache_beats   = icache_blocksize / icache_memw;
  localparam int icache_offbits = $clog2(icache_blocksize / 8);
  localparam int icache_idxbits = $clog2(icache_noofsets);
  localparam int icache_tagbits =
    icache_pc_size - icache_offbits - icache_idxbits;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    DATA,
    DRAIN,
    WRITE
  } refill_state_t;

endpackage

// File: rtl/icache_line_buf.sv
// Beat-indexed line assembly buffer with beat counter.
// Ports: clr_i/wipe_i reset count/data, beat_i counts, store_i writes data_i.
module icache_line_buf #(
  parameter int MEM_W      = 32,
  parameter int BLOCK_BITS = 512,
  localparam int BEATS     = BLOCK_BITS / MEM_W,
  localparam int CNT_W     = $clog2(BEATS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  wipe_i,
  input  logic                  beat_i,
  input  logic                  store_i,
  input  logic [MEM_W-1:0]      data_i,
  output logic                  last_beat_o,
  output logic [BLOCK_BITS-1:0] line_o
);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BLOCK_BITS-1:0] line_q, line_d;

  always_comb begin
    cnt_d  = cnt_q;
    line_d = line_q;
    if (wipe_i) line_d = '0;
    if (clr_i) cnt_d = '0;
    else if (beat_i) cnt_d = cnt_q + 1'b1;
    if (store_i)
      line_d[int'(cnt_q)*MEM_W +: MEM_W] = data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      line_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      line_q <= line_d;
    end
  end

  assign last_beat_o = beat_i && (cnt_q == CNT_W'(BEATS - 1));
  assign line_o      = line_q;

endmodule

// File: rtl/icache_refill_ctrl.sv
// I-cache miss handler: one aligned burst read, line assembly, array write.
// Ports: miss/flush from fetch, mem_* burst bus, line_* cache array write.
module icache_refill_ctrl
  import icache_refill_pkg::*;
#(
  parameter int ADDR_W     = icache_pc_size,
  parameter int MEM_W      = icache_memw,
  parameter int BLOCK_BITS = icache_blocksize,
  parameter int NUM_SETS   = icache_noofsets,
  localparam int OFF_W     = $clog2(BLOCK_BITS / 8),
  localparam int IDX_W     = $clog2(NUM_SETS),
  localparam int TAG_W     = ADDR_W - OFF_W - IDX_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  miss_i,
  input  logic [ADDR_W-1:0]     miss_addr_i,
  input  logic                  flush_i,
  output logic                  refill_busy_o,
  output logic                  refill_done_o,
  output logic                  mem_req_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [MEM_W-1:0]      mem_rdata_i,
  output logic                  line_we_o,
  output logic [IDX_W-1:0]      line_set_o,
  output logic [TAG_W-1:0]      line_tag_o,
  output logic [BLOCK_BITS-1:0] line_data_o
);

  localparam logic [ADDR_W-1:0] OFF_MASK =
    ADDR_W'((1 << OFF_W) - 1);

  refill_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic accept;
  logic cnt_clr;
  logic beat;
  logic store;
  logic last_beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (miss_i && !flush_i) state_d = REQ;
      end
      REQ: begin
        if (mem_gnt_i)
          state_d = flush_i ? DRAIN : DATA;
        else if (flush_i)
          state_d = IDLE;
      end
      DATA: begin
        // A flush on the final beat leaves nothing to drain.
        if (last_beat)
          state_d = flush_i ? IDLE : WRITE;
        else if (flush_i)
          state_d = DRAIN;
      end
      DRAIN: begin
        if (last_beat) state_d = IDLE;
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    refill_busy_o = 1'b1;
    refill_done_o = 1'b0;
    mem_req_o     = 1'b0;
    line_we_o     = 1'b0;
    accept        = 1'b0;
    cnt_clr       = 1'b0;
    beat          = 1'b0;
    store         = 1'b0;
    unique case (state_q)
      IDLE: begin
        refill_busy_o = 1'b0;
        accept        = miss_i && !flush_i;
      end
      REQ: begin
        mem_req_o = 1'b1;
        cnt_clr   = mem_gnt_i;
      end
      DATA: begin
        beat  = mem_rvalid_i;
        store = mem_rvalid_i;
      end
      DRAIN: begin
        beat = mem_rvalid_i;
      end
      WRITE: begin
        refill_done_o = 1'b1;
        line_we_o     = 1'b1;
      end
      default: refill_busy_o = 1'b0;
    endcase
  end

  assign addr_d = accept ? (miss_addr_i & ~OFF_MASK) : addr_q;

  assign mem_addr_o = mem_req_o ? addr_q : '0;
  assign line_set_o = addr_q[OFF_W +: IDX_W];
  assign line_tag_o = addr_q[ADDR_W-1 -: TAG_W];

  // The old line is wiped when a new refill is accepted so that an
  // aborted burst never leaves words behind in the next line.
  icache_line_buf #(
    .MEM_W      (MEM_W),
    .BLOCK_BITS (BLOCK_BITS)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (cnt_clr),
    .wipe_i      (accept),
    .beat_i      (beat),
    .store_i     (store),
    .data_i      (mem_rdata_i),
    .last_beat_o (last_beat),
    .line_o      (line_data_o)
  );

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl.
// Table-driven refills plus flush and reset sequences, scoreboarded.
module tb_icache_refill_ctrl;
  import icache_refill_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         miss_i = 1'b0;
  logic [31:0]  miss_addr_i = '0;
  logic         flush_i = 1'b0;
  logic         refill_busy_o;
  logic         refill_done_o;
  logic         mem_req_o;
  logic [31:0]  mem_addr_o;
  logic         mem_gnt_i = 1'b0;
  logic         mem_rvalid_i = 1'b0;
  logic [31:0]  mem_rdata_i = '0;
  logic         line_we_o;
  logic [5:0]   line_set_o;
  logic [19:0]  line_tag_o;
  logic [511:0] line_data_o;

  always #5 clk = ~clk;

  icache_refill_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .miss_i        (miss_i),
    .miss_addr_i   (miss_addr_i),
    .flush_i       (flush_i),
    .refill_busy_o (refill_busy_o),
    .refill_done_o (refill_done_o),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i),
    .line_we_o     (line_we_o),
    .line_set_o    (line_set_o),
    .line_tag_o    (line_tag_o),
    .line_data_o   (line_data_o)
  );

  typedef struct {
    logic [31:0] addr;
    int          gdly;
    int          gap;
    logic [31:0] base;
    logic [5:0]  set;
    logic [19:0] tag;
    bit          tog;
  } vec_t;

  typedef struct {
    logic [5:0]   set;
    logic [19:0]  tag;
    logic [511:0] line;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  vec_t vt[7];
  int total = 0;
  int bad = 0;
  int we_cnt = 0;
  int we0;

  task automatic chk(string nm, logic [511:0] act,
                     logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (line_we_o || refill_done_o)
      chk("done_we", refill_done_o, line_we_o);
    if (line_we_o === 1'b1) begin
      we_cnt++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL stray_write set=%0h tag=%0h want none",
                 line_set_o, line_tag_o);
      end else begin
        e = sb.pop_front();
        chk("set", line_set_o, e.set);
        chk("tag", line_tag_o, e.tag);
        chk("line", line_data_o, e.line);
      end
    end
  end

  task automatic run_refill(vec_t v);
    logic [511:0] ln;
    logic [31:0]  blk;
    blk = v.addr & 32'hFFFF_FFC0;
    for (int k = 0; k < 16; k++)
      ln[32*k +: 32] = v.base + 32'(k);
    miss_i      = 1'b1;
    miss_addr_i = v.addr;
    sb.push_back('{v.set, v.tag, ln});
    tick();
    chk("busy", refill_busy_o, 1'b1);
    repeat (v.gdly) begin
      chk("req_hold", mem_req_o, 1'b1);
      chk("addr_hold", mem_addr_o, blk);
      tick();
    end
    chk("req", mem_req_o, 1'b1);
    chk("addr", mem_addr_o, blk);
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    chk("req_drop", mem_req_o, 1'b0);
    for (int k = 0; k < 16; k++) begin
      repeat (v.gap) begin
        mem_rdata_i = $urandom;
        tick();
      end
      if (v.tog && k >= 3 && k <= 6) begin
        miss_i      = k[0];
        miss_addr_i = 32'h7777_7740;
      end
      if (k == 15) chk("no_early_we", line_we_o, 1'b0);
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = v.base + 32'(k);
      tick();
      mem_rvalid_i = 1'b0;
    end
    chk("we_on_time", line_we_o, 1'b1);
    miss_i = 1'b0;
    tick();
    chk("we_pulse", line_we_o, 1'b0);
    chk("idle", refill_busy_o, 1'b0);
    chk("line_held", line_data_o, ln);
  endtask

  initial begin
    vt[0] = '{32'h0000_1234, 0, 0, 32'hA000_0000,
              6'd8, 20'h00001, 1'b0};
    vt[1] = '{32'h0000_1234, 5, 0, 32'hA000_0000,
              6'd8, 20'h00001, 1'b0};
    vt[2] = '{32'h0000_1234, 0, 3, 32'hA000_0000,
              6'd8, 20'h00001, 1'b0};
    vt[3] = '{32'hFFFF_FFC0, 2, 1, 32'h5A5A_0000,
              6'd63, 20'hFFFFF, 1'b0};
    vt[4] = '{32'h0000_0040, 1, 0, 32'hC0DE_0000,
              6'd1, 20'h00000, 1'b0};
    vt[5] = '{32'hDEAD_BEEF, 0, 1, 32'h0BAD_F000,
              6'd59, 20'hDEADB, 1'b1};
    vt[6] = '{32'h0000_2000, 0, 0, 32'h1357_0000,
              6'd0, 20'h00002, 1'b0};

    #12;
    chk("rst_busy", refill_busy_o, 1'b0);
    chk("rst_req", mem_req_o, 1'b0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_we", line_we_o, 1'b0);
    chk("rst_line", line_data_o, 512'h0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    for (int i = 0; i < 3; i++) run_refill(vt[i]);

    we0 = we_cnt;
    miss_i      = 1'b1;
    miss_addr_i = 32'h0000_0100;
    tick();
    miss_i = 1'b0;
    chk("fr_req", mem_req_o, 1'b1);
    tick();
    chk("fr_req2", mem_req_o, 1'b1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("fr_req_low", mem_req_o, 1'b0);
    chk("fr_idle", refill_busy_o, 1'b0);
    run_refill(vt[3]);
    chk("fr_no_we", we_cnt, we0 + 1);

    run_refill(vt[5]);

    we0 = we_cnt;
    miss_i      = 1'b1;
    miss_addr_i = 32'h0000_2000;
    tick();
    miss_i    = 1'b0;
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    for (int k = 0; k < 7; k++) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hBAD0_0000 + 32'(k);
      tick();
      mem_rvalid_i = 1'b0;
    end
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    for (int k = 0; k < 9; k++) begin
      chk("drain_busy", refill_busy_o, 1'b1);
      flush_i      = (k == 2);
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hDEAD_0000 + 32'(k);
      tick();
      mem_rvalid_i = 1'b0;
      flush_i      = 1'b0;
    end
    chk("drain_idle", refill_busy_o, 1'b0);
    chk("drain_no_we", we_cnt, we0);
    run_refill(vt[6]);

    miss_i      = 1'b1;
    miss_addr_i = 32'h0000_3000;
    tick();
    miss_i    = 1'b0;
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    repeat (5) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h3333_3333;
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("mr_busy", refill_busy_o, 1'b0);
    chk("mr_req", mem_req_o, 1'b0);
    chk("mr_set", line_set_o, 6'd0);
    chk("mr_tag", line_tag_o, 20'd0);
    chk("mr_line", line_data_o, 512'h0);
    mem_rvalid_i = 1'b0;
    tick();
    tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
    run_refill(vt[4]);

    tick();
    chk("sb_empty", sb.size(), 0);
    chk("we_count", we_cnt, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
